// File: rtl/game_pkg.sv
// Shared types and constants for the game score controller.
// State encodings are fixed because they are visible on the state output.
package game_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPlay     = 2'd1,
        StHitPause = 2'd2,
        StGameOver = 2'd3
    } game_state_e;

    localparam int unsigned BcdW     = 4;
    localparam logic [3:0]  LevelMax = 4'd15;

endpackage

// File: rtl/bcd_add_sat.sv
// Multi-digit BCD adder of a single-digit addend; clamps to all-9s instead of wrapping.
module bcd_add_sat
    import game_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic [BcdW*DIGITS-1:0] a_i,
    input  logic [BcdW-1:0]        b_i,
    output logic [BcdW*DIGITS-1:0] sum_o
);

    logic [BcdW*DIGITS-1:0] raw;
    logic [4:0]             digit_sum;
    logic [4:0]             carry;

    always_comb begin
        raw       = '0;
        digit_sum = '0;
        carry     = {1'b0, b_i};
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, a_i[i*BcdW +: BcdW]} + carry;
            if (digit_sum > 5'd9) begin
                raw[i*BcdW +: BcdW] = 4'(digit_sum - 5'd10);
                carry               = 5'd1;
            end else begin
                raw[i*BcdW +: BcdW] = digit_sum[3:0];
                carry               = 5'd0;
            end
        end
        // Carry out of the top digit means the true sum no longer fits.
        sum_o = (carry != 5'd0) ? {DIGITS{4'd9}} : raw;
    end

endmodule

// File: rtl/game_score_ctrl.sv
// Game score/lives/level controller with a registered IDLE/PLAY/HIT_PAUSE/GAME_OVER FSM.
// Optional high-score register is enabled by defining GAME_HIGH_SCORE_EN.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT       = 3,
    parameter int unsigned SCORE_DIGITS     = 2,
    parameter int unsigned POINTS_PER_KILL  = 1,
    parameter int unsigned WAVE_SIZE        = 55,
    parameter int unsigned HIT_PAUSE_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         start,
    input  logic                         invader_collision,
    input  logic                         player_collision,
    output logic [2:0]                   lives,
    output logic [BcdW*SCORE_DIGITS-1:0] score,
    output logic [3:0]                   level,
    output logic [1:0]                   state,
    output logic                         freeze,
    output logic                         game_over
`ifdef GAME_HIGH_SCORE_EN
    ,
    output logic [BcdW*SCORE_DIGITS-1:0] high_score
`endif
);

    localparam int unsigned ScoreW    = BcdW * SCORE_DIGITS;
    localparam int unsigned PauseW    = (HIT_PAUSE_CYCLES > 1) ? $clog2(HIT_PAUSE_CYCLES) : 1;
    localparam logic [PauseW-1:0] PauseLast = PauseW'(HIT_PAUSE_CYCLES - 1);
    localparam logic [7:0]        KillLast  = 8'(WAVE_SIZE - 1);

    game_state_e       state_q, state_d;
    logic [2:0]        lives_q, lives_d;
    logic [ScoreW-1:0] score_q, score_d;
    logic [3:0]        level_q, level_d;
    logic [7:0]        kills_q, kills_d;
    logic [PauseW-1:0] pause_q, pause_d;
    logic              start_q, invader_q, player_q;

    logic              start_edge, invader_edge, player_edge;
    logic [ScoreW-1:0] score_inc;

    assign start_edge   = start & ~start_q;
    assign invader_edge = invader_collision & ~invader_q;
    assign player_edge  = player_collision & ~player_q;

    bcd_add_sat #(
        .DIGITS (SCORE_DIGITS)
    ) u_bcd_add_sat (
        .a_i   (score_q),
        .b_i   (4'(POINTS_PER_KILL)),
        .sum_o (score_inc)
    );

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        level_d = level_q;
        kills_d = kills_q;
        pause_d = pause_q;
        case (state_q)
            StIdle, StGameOver: begin
                if (start_edge) begin
                    state_d = StPlay;
                    lives_d = 3'(LIVES_INIT);
                    score_d = '0;
                    level_d = 4'd1;
                    kills_d = '0;
                end
            end
            StPlay: begin
                // Kill is applied before the life loss so a simultaneous hit still scores.
                if (invader_edge) begin
                    score_d = score_inc;
                    if (kills_q == KillLast) begin
                        kills_d = '0;
                        if (level_q != LevelMax) level_d = level_q + 4'd1;
                    end else begin
                        kills_d = kills_q + 8'd1;
                    end
                end
                if (player_edge) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = StHitPause;
                        pause_d = '0;
                    end else begin
                        lives_d = 3'd0;
                        state_d = StGameOver;
                    end
                end
            end
            StHitPause: begin
                if (pause_q == PauseLast) begin
                    pause_d = '0;
                    state_d = StPlay;
                end else begin
                    pause_d = pause_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StIdle;
            lives_q   <= 3'(LIVES_INIT);
            score_q   <= '0;
            level_q   <= 4'd1;
            kills_q   <= '0;
            pause_q   <= '0;
            start_q   <= 1'b0;
            invader_q <= 1'b0;
            player_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            level_q   <= level_d;
            kills_q   <= kills_d;
            pause_q   <= pause_d;
            start_q   <= start;
            invader_q <= invader_collision;
            player_q  <= player_collision;
        end
    end

`ifdef GAME_HIGH_SCORE_EN
    logic [ScoreW-1:0] high_score_q, high_score_d;

    // Packed BCD compares correctly as plain binary since every digit is 0..9.
    always_comb begin
        high_score_d = high_score_q;
        if (state_q != StGameOver && state_d == StGameOver && score_d > high_score_q) begin
            high_score_d = score_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) high_score_q <= '0;
        else         high_score_q <= high_score_d;
    end

    assign high_score = high_score_q;
`endif

    assign lives     = lives_q;
    assign score     = score_q;
    assign level     = level_q;
    assign state     = state_q;
    assign freeze    = (state_q == StHitPause);
    assign game_over = (state_q == StGameOver);

endmodule

// File: tb/tb_game_score_ctrl.sv
// Self-checking bench for game_score_ctrl: directed scenarios plus random play against
// an integer-level game model. Define GAME_HIGH_SCORE_EN to also check high_score.
module tb_game_score_ctrl;

    localparam int LI   = 3;
    localparam int SD   = 2;
    localparam int PPK  = 1;
    localparam int WAVE = 4;
    localparam int HPC  = 20;
    localparam int SMAX = 10 ** SD - 1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start, invader_collision, player_collision;
    logic [2:0]    lives;
    logic [4*SD-1:0] score;
    logic [3:0]    level;
    logic [1:0]    state;
    logic          freeze, game_over;
`ifdef GAME_HIGH_SCORE_EN
    logic [4*SD-1:0] high_score;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    game_score_ctrl #(
        .LIVES_INIT       (LI),
        .SCORE_DIGITS     (SD),
        .POINTS_PER_KILL  (PPK),
        .WAVE_SIZE        (WAVE),
        .HIT_PAUSE_CYCLES (HPC)
    ) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .start             (start),
        .invader_collision (invader_collision),
        .player_collision  (player_collision),
        .lives             (lives),
        .score             (score),
        .level             (level),
        .state             (state),
        .freeze            (freeze),
        .game_over         (game_over)
`ifdef GAME_HIGH_SCORE_EN
        ,
        .high_score        (high_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*SD-1:0] to_bcd(input int v);
        logic [4*SD-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < SD; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Game model in plain integers: 0 idle, 1 play, 2 paused, 3 over.
    int m_state, m_lives, m_score, m_level, m_kills, m_pause_left, m_hs;
    bit m_ps, m_pi, m_pp;

    task automatic model_reset();
        m_state = 0; m_lives = LI; m_score = 0; m_level = 1; m_kills = 0;
        m_pause_left = 0; m_hs = 0;
        m_ps = 0; m_pi = 0; m_pp = 0;
    endtask

    task automatic model_step();
        bit se, ie, pe;
        se = start && !m_ps;
        ie = invader_collision && !m_pi;
        pe = player_collision && !m_pp;
        m_ps = start; m_pi = invader_collision; m_pp = player_collision;
        if (m_state == 0 || m_state == 3) begin
            if (se) begin
                m_state = 1; m_lives = LI; m_score = 0; m_level = 1; m_kills = 0;
            end
        end else if (m_state == 1) begin
            if (ie) begin
                m_score = (m_score + PPK > SMAX) ? SMAX : m_score + PPK;
                m_kills++;
                if (m_kills == WAVE) begin
                    m_kills = 0;
                    if (m_level < 15) m_level++;
                end
            end
            if (pe) begin
                if (m_lives > 1) begin
                    m_lives--; m_state = 2; m_pause_left = HPC;
                end else begin
                    m_lives = 0; m_state = 3;
                    if (m_score > m_hs) m_hs = m_score;
                end
            end
        end else begin
            m_pause_left--;
            if (m_pause_left == 0) m_state = 1;
        end
    endtask

    always @(posedge clk) begin
        if (!arst_n) model_reset();
        else         model_step();
        #1;
        check("state", 32'(state), 32'(m_state));
        check("lives", 32'(lives), 32'(m_lives));
        check("score", 32'(score), 32'(to_bcd(m_score)));
        check("level", 32'(level), 32'(m_level));
        check("freeze", 32'(freeze), 32'(m_state == 2));
        check("game_over", 32'(game_over), 32'(m_state == 3));
`ifdef GAME_HIGH_SCORE_EN
        check("high_score", 32'(high_score), 32'(to_bcd(m_hs)));
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kill();
        invader_collision = 1'b1; cyc(1);
        invader_collision = 1'b0; cyc(1);
    endtask

    task automatic hit_and_wait();
        player_collision = 1'b1; cyc(1);
        player_collision = 1'b0; cyc(HPC + 5);
    endtask

    initial begin
        int n;
        model_reset();
        arst_n = 1'b0; start = 1'b0; invader_collision = 1'b0; player_collision = 1'b0;
        cyc(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_score", 32'(score), 32'h00);
        check("rst_level", 32'(level), 32'd1);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        arst_n = 1'b1; cyc(1);

        start = 1'b1; cyc(1);
        check("start_state", 32'(state), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_score", 32'(score), 32'h00);
        check("start_level", 32'(level), 32'd1);
        start = 1'b0;

        invader_collision = 1'b1; cyc(10);
        check("held_kill_once", 32'(score), 32'h01);
        invader_collision = 1'b0; cyc(1);
        invader_collision = 1'b1; cyc(1);
        check("second_kill", 32'(score), 32'h02);
        invader_collision = 1'b0; cyc(1);

        kill();
        invader_collision = 1'b1; cyc(1);
        check("wave_level", 32'(level), 32'd2);
        check("wave_score", 32'(score), 32'h04);
        invader_collision = 1'b0; cyc(1);

        repeat (95) kill();
        check("score_99", 32'(score), 32'h99);
        check("level_sat", 32'(level), 32'd15);
        kill();
        check("score_sat", 32'(score), 32'h99);

        player_collision = 1'b1; cyc(1);
        check("hit1_lives", 32'(lives), 32'd2);
        check("hit1_freeze", 32'(freeze), 32'd1);
        player_collision = 1'b0;
        n = 1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (freeze) n++;
            else break;
        end
        check("pause_len", 32'(n), 32'(HPC));
        check("pause_back_play", 32'(state), 32'd1);

        hit_and_wait();
        check("hit2_lives", 32'(lives), 32'd1);
        player_collision = 1'b1; cyc(1);
        check("hit3_lives", 32'(lives), 32'd0);
        check("hit3_game_over", 32'(game_over), 32'd1);
        player_collision = 1'b0; cyc(1);
`ifdef GAME_HIGH_SCORE_EN
        check("hs_first", 32'(high_score), 32'h99);
`endif
        start = 1'b1; cyc(1);
        check("restart_state", 32'(state), 32'd1);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_score", 32'(score), 32'h00);
        start = 1'b0; cyc(1);

        // Asynchronous reset mid-game, checked before any clock edge.
        kill();
        arst_n = 1'b0; #1;
        check("async_state", 32'(state), 32'd0);
        check("async_score", 32'(score), 32'h00);
        check("async_lives", 32'(lives), 32'd3);
        cyc(1);
        arst_n = 1'b1; cyc(1);

        start = 1'b1; cyc(1);
        start = 1'b0; cyc(1);
        kill(); kill();
        hit_and_wait(); hit_and_wait();
        check("pre_simul_lives", 32'(lives), 32'd1);
        invader_collision = 1'b1; player_collision = 1'b1; cyc(1);
        check("simul_score", 32'(score), 32'h03);
        check("simul_state", 32'(state), 32'd3);
        check("simul_lives", 32'(lives), 32'd0);
`ifdef GAME_HIGH_SCORE_EN
        check("simul_hs", 32'(high_score), 32'h03);
`endif
        invader_collision = 1'b0; player_collision = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        check("simul_restart", 32'(state), 32'd1);
`ifdef GAME_HIGH_SCORE_EN
        check("hs_kept", 32'(high_score), 32'h03);
`endif
        start = 1'b0; cyc(1);

        for (int i = 0; i < 4000; i++) begin
            start             = ($urandom_range(0, 40) == 0);
            invader_collision = ($urandom_range(0, 2) == 0);
            player_collision  = ($urandom_range(0, 30) == 0);
            arst_n            = ($urandom_range(0, 700) != 0);
            cyc(1);
        end
        arst_n = 1'b1; start = 1'b0; invader_collision = 1'b0; player_collision = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_score_ctrl.md
GAME_SCORE_CTRL -- requirements
Module: game_score_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start (1..7).
REQ-002 Parameter SCORE_DIGITS, default 2: BCD score digits (1..4).
REQ-003 Parameter POINTS_PER_KILL, default 1: BCD points per invader kill (1..9).
REQ-004 Parameter WAVE_SIZE, default 55: kills that clear one wave (1..255).
REQ-005 Parameter HIT_PAUSE_CYCLES, default 1000: freeze duration after player hit (>=1).
REQ-006 clk  input  1  system clock; the block has one clock, and reset is asynchronous and active-low.
REQ-007 arst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  debounced start/restart request, level.
REQ-009 invader_collision  input  1  level; high while a shot overlaps an invader.
REQ-010 player_collision  input  1  level; high while a shot overlaps the player.
REQ-011 lives  output  3  remaining lives.
REQ-012 score  output  4*SCORE_DIGITS  BCD score, digit 0 in LSBs.
REQ-013 level  output  4  current wave number, 1..15.
REQ-014 state  output  2  FSM state encoding.
REQ-015 freeze  output  1  high in HIT_PAUSE; gameplay halts.
REQ-016 game_over  output  1  high in GAME_OVER.

Function
REQ-017 FSM states: IDLE=0, PLAY=1, HIT_PAUSE=2, GAME_OVER=3, registered.
REQ-018 Rising-edge detect on start, invader_collision and player_collision; each edge is one event, and a held level counts once.
REQ-019 IDLE or GAME_OVER + start edge -> PLAY on the next cycle; lives=LIVES_INIT, score=0, level=1, kill count=0.
REQ-020 PLAY + invader edge -> score += POINTS_PER_KILL (BCD, 1-cycle latency); kill count increments.
REQ-021 Score saturates at all-9s; no wrap.
REQ-022 Kill count reaching WAVE_SIZE -> kill count=0, level+1 in the same cycle; level saturates at 15.
REQ-023 PLAY + player edge: lives>1 -> lives-1, go to HIT_PAUSE; lives==1 -> lives=0, go to GAME_OVER.
REQ-024 Simultaneous invader and player edges in PLAY: both applied in the same cycle, score first, then life loss.
REQ-025 HIT_PAUSE lasts exactly HIT_PAUSE_CYCLES cycles, then returns to PLAY; collision edges during the pause are ignored.
REQ-026 Invader and player edges in IDLE or GAME_OVER are ignored.
REQ-027 A start edge in PLAY or HIT_PAUSE is ignored.
REQ-028 Outputs are registered; game_over and freeze are decoded from the state register.

Reset
REQ-029 arst_n low -> state=IDLE, lives=LIVES_INIT, score=0, level=1, freeze=0, game_over=0, edge-detect history=0, pause counter=0.
REQ-030 Reset asserted mid-game takes effect immediately and asynchronously; deassertion is synchronous to clk.

Configuration
REQ-031 Macro GAME_HIGH_SCORE_EN.
- Defined: adds output high_score (4*SCORE_DIGITS). It is updated on entry to GAME_OVER when score > high_score, cleared only by arst_n, and kept across restarts.
- Undefined: the high_score port and register are absent.

Structure
REQ-032 The following belong in the shared package game_pkg: state encodings, BCD digit width, and the level maximum.
REQ-033 One sub-module, bcd_add_sat: a SCORE_DIGITS-digit BCD adder of a 1-digit addend with all-9s saturation (combinational, instantiated once).

Verification
REQ-034 Reset, start edge -> after 1 cycle: state=1, lives=3, score=0x00, level=1.
REQ-035 Invader collision held high for 10 cycles in PLAY -> score=0x01 only; a second edge -> 0x02.
REQ-036 Score 0x99 plus a kill -> score stays 0x99.
REQ-037 WAVE_SIZE=4, four kills -> level=2 on the cycle of the 4th kill.
REQ-038 Player hit with lives=3 -> lives=2, freeze=1 for exactly HIT_PAUSE_CYCLES cycles. A third hit -> lives=0, game_over=1; start -> PLAY, lives=3.
REQ-039 Simultaneous invader and player edges with lives=1 -> score+1, GAME_OVER. With GAME_HIGH_SCORE_EN defined, high_score = final score, and it survives a restart.
